ball_speed_resolver: RTL
========================

// Module: ball_speed_resolver
// PURPOSE
// Per-ball velocity register file; consumes game_controller collision pulses. Applies wall reflection,
// ball-ball velocity exchange, cue-shot load and per-frame friction. Feeds the per-ball movement blocks.
// Collision pulses are latched into pending registers and serviced by a small FSM; none are lost.
// PARAMETERS
// NUM_BALLS       3    number of balls, ball 0 = white/cue ball (max 16)
// SPEED_W         11   signed speed width (two's complement)
// FRICTION_SHIFT  6    per-frame decay = |v| >> FRICTION_SHIFT, minimum 1
// MAX_SPEED       255  shot speed saturation magnitude
// PORTS
// clk             in   1                    system clock
// reset           in   1                    asynchronous, active-high reset
// startOfFrame    in   1                    one-cycle pulse per frame; triggers friction sweep
// shot_valid      in   1                    one-cycle cue strike request
// shot_x_speed    in   SPEED_W              signed X speed for ball 0
// shot_y_speed    in   SPEED_W              signed Y speed for ball 0
// balls_in_game   in   NUM_BALLS            1 = ball on table
// ballwall_collide in  NUM_BALLS            one-cycle pulse vector, balls hitting a wall
// collided_wall   in   2                    bit0 = vertical wall (negate X), bit1 = horizontal wall (negate Y)
// balls_collide   in   NUM_BALLS            one-cycle pulse vector, ball-ball event when nonzero
// Balls_col_ID    in   2x4                  IDs of the two colliding balls, valid with balls_collide
// x_speed         out  NUM_BALLS x SPEED_W  current signed X speed per ball
// y_speed         out  NUM_BALLS x SPEED_W  current signed Y speed per ball
// all_stopped     out  1                    1 when all speeds are zero
// busy            out  1                    FSM not in IDLE
// event_dropped   out  1                    one-cycle pulse when a ball-ball event is discarded
// BEHAVIOUR
// - Reset: all speeds 0, all_stopped=1, busy=0, event_dropped=0, pending cleared, FSM=IDLE.
// - Pending capture, every cycle, all states:
//   - Wall: pend_wall_vec |= ballwall_collide; pend_wall_dir |= collided_wall.
//   - Ball-ball: IDs and a valid bit are captured when balls_collide != 0.
//   - A second ball-ball event while one is already pending is dropped; event_dropped pulses.
//   - Sweep request sets on startOfFrame. Shot request sets on shot_valid.
//   - Capture also happens in the cycle a pending entry is consumed, so no event is lost.
// - FSM: IDLE -> priority SWEEP > WALL > BALL > SHOT; each applied state returns to IDLE.
//   - IDLE: one cycle; selects the highest-priority pending request.
//   - SWEEP: one ball per cycle, index 0..NUM_BALLS-1, NUM_BALLS cycles. For each component:
//     v' = sign(v) * max(|v| - max(1, |v| >> FRICTION_SHIFT), 0). A zero speed stays 0.
//   - WALL: single cycle. For every flagged ball, negate X if dir[0] and negate Y if dir[1].
//     Negating -2^(SPEED_W-1) saturates to +2^(SPEED_W-1)-1. Then clear the wall pending.
//   - BALL: single cycle. Swap {x,y} speeds of ID0 and ID1 (equal-mass elastic approximation).
//     The event is ignored if ID0 == ID1 or either ID >= NUM_BALLS.
//   - SHOT: accepted only if all_stopped=1 and balls_in_game[0]=1; otherwise discarded.
//     Loads ball 0 with shot speeds clamped to +/-MAX_SPEED.
// - Latency: with the FSM in IDLE, a pulse at edge t updates the speeds at edge t+2.
//   A pending request waits for the current sweep to finish.
// - Out-of-game ball: its speeds are forced to 0 at the next edge, overriding any FSM write that cycle.
// - all_stopped and busy are registered and derived from the post-update state.
// - The team's design guarantees a full service pass completes within a frame.
//   If startOfFrame arrives during SWEEP, the sweep request stays set and the sweep reruns afterwards.
// - Reset mid-operation: immediate return to reset values; in-flight sweep and pending events are discarded.
// TESTING
// - Reset, then shot_valid with (+300,-40) -> ball0 = (+255,-40), all_stopped=0 two edges later.
// - ball1=(64,0), shift 6, startOfFrame -> ball1 becomes (63,0). Repeat 64 frames -> (0,0), all_stopped=1.
// - ball1=(20,-5), ballwall_collide=010 with collided_wall=11 -> ball1=(-20,5) after 2 cycles.
// - ball0=(10,3), ball2=(0,0), balls_collide pulse with IDs {0,2} -> ball0=(0,0), ball2=(10,3). IDs {1,1} -> no change.
// - Wall and ball pulses in the same cycle as startOfFrame -> sweep first, then wall, then swap; final values checked.
// - Two ball-ball pulses while busy -> event_dropped pulses once. balls_in_game[1]=0 -> ball1 speed 0 at the next edge.

Source files
------------

// File: rtl/ball_speed_resolver.sv
// ball_speed_resolver: per-ball velocity register file with wall reflection, ball-ball swap, cue shot and friction.
// Collision and frame pulses are latched as pending requests and serviced one at a time by a small FSM.
module ball_speed_resolver #(
    parameter int NUM_BALLS      = 3,
    parameter int SPEED_W        = 11,
    parameter int FRICTION_SHIFT = 6,
    parameter int MAX_SPEED      = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic                         shot_valid,
    input  logic [SPEED_W-1:0]           shot_x_speed,
    input  logic [SPEED_W-1:0]           shot_y_speed,
    input  logic [NUM_BALLS-1:0]         balls_in_game,
    input  logic [NUM_BALLS-1:0]         ballwall_collide,
    input  logic [1:0]                   collided_wall,
    input  logic [NUM_BALLS-1:0]         balls_collide,
    input  logic [7:0]                   Balls_col_ID,
    output logic [NUM_BALLS*SPEED_W-1:0] x_speed,
    output logic [NUM_BALLS*SPEED_W-1:0] y_speed,
    output logic                         all_stopped,
    output logic                         busy,
    output logic                         event_dropped
);
    localparam int IW = NUM_BALLS > 1 ? $clog2(NUM_BALLS) : 1;
    typedef logic signed [SPEED_W-1:0] spd_t;
    typedef enum logic [2:0] {IDLE, SWEEP, WALL, BALL, SHOT} state_t;
    localparam spd_t SMAX = spd_t'({1'b0, {(SPEED_W-1){1'b1}}});
    localparam spd_t SMIN = spd_t'({1'b1, {(SPEED_W-1){1'b0}}});
    localparam spd_t CMAX = spd_t'(MAX_SPEED);
    localparam spd_t CMIN = -CMAX;

    state_t               state, nstate;
    spd_t                 vx [NUM_BALLS];
    spd_t                 vy [NUM_BALLS];
    spd_t                 nx [NUM_BALLS];
    spd_t                 ny [NUM_BALLS];
    spd_t                 shot_x, shot_y;
    logic [IW-1:0]        idx;
    logic [NUM_BALLS-1:0] pend_wall_vec;
    logic [1:0]           pend_wall_dir;
    logic                 pend_ball, pend_sweep, pend_shot, stop, ball_ok;
    logic [3:0]           pend_id0, pend_id1;

    // Magnitude is handled unsigned so the most negative speed still has a representable |v|.
    function automatic spd_t fric(spd_t v);
        logic [SPEED_W-1:0] a, d, r;
        a = v[SPEED_W-1] ? -v : v;
        d = a >> FRICTION_SHIFT;
        d = (d == '0) ? SPEED_W'(1) : d;
        r = (a > d) ? a - d : '0;
        return v[SPEED_W-1] ? spd_t'(-r) : spd_t'(r);
    endfunction

    function automatic spd_t neg(spd_t v);
        return (v == SMIN) ? SMAX : -v;
    endfunction

    function automatic spd_t clamp(spd_t v);
        return (v > CMAX) ? CMAX : (v < CMIN) ? CMIN : v;
    endfunction

    always_comb begin
        nstate  = state;
        nx      = vx;
        ny      = vy;
        ball_ok = pend_id0 != pend_id1 && int'(pend_id0) < NUM_BALLS && int'(pend_id1) < NUM_BALLS;
        case (state)
            IDLE: nstate = pend_sweep ? SWEEP : |pend_wall_vec ? WALL : pend_ball ? BALL : pend_shot ? SHOT : IDLE;
            SWEEP: begin
                for (int i = 0; i < NUM_BALLS; i++)
                    if (int'(idx) == i) begin
                        nx[i] = fric(vx[i]);
                        ny[i] = fric(vy[i]);
                    end
                nstate = (int'(idx) == NUM_BALLS-1) ? IDLE : SWEEP;
            end
            WALL: begin
                for (int i = 0; i < NUM_BALLS; i++) begin
                    if (pend_wall_vec[i] && pend_wall_dir[0]) nx[i] = neg(vx[i]);
                    if (pend_wall_vec[i] && pend_wall_dir[1]) ny[i] = neg(vy[i]);
                end
                nstate = IDLE;
            end
            BALL: begin
                for (int i = 0; i < NUM_BALLS; i++)
                    for (int j = 0; j < NUM_BALLS; j++)
                        if (ball_ok && i == int'(pend_id0) && j == int'(pend_id1)) begin
                            nx[i] = vx[j];
                            ny[i] = vy[j];
                            nx[j] = vx[i];
                            ny[j] = vy[i];
                        end
                nstate = IDLE;
            end
            SHOT: begin
                if (all_stopped && balls_in_game[0]) begin
                    nx[0] = clamp(shot_x);
                    ny[0] = clamp(shot_y);
                end
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
        stop = 1'b1;
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (!balls_in_game[i]) begin
                nx[i] = '0;
                ny[i] = '0;
            end
            stop = stop && nx[i] == '0 && ny[i] == '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            for (int i = 0; i < NUM_BALLS; i++) begin
                vx[i] <= '0;
                vy[i] <= '0;
            end
            idx           <= '0;
            pend_wall_vec <= '0;
            pend_wall_dir <= '0;
            pend_ball     <= 1'b0;
            pend_id0      <= '0;
            pend_id1      <= '0;
            pend_sweep    <= 1'b0;
            pend_shot     <= 1'b0;
            shot_x        <= '0;
            shot_y        <= '0;
            event_dropped <= 1'b0;
            all_stopped   <= 1'b1;
            busy          <= 1'b0;
        end else begin
            state         <= nstate;
            vx            <= nx;
            vy            <= ny;
            idx           <= (state == SWEEP && int'(idx) != NUM_BALLS-1) ? idx + IW'(1) : '0;
            pend_wall_vec <= (state == WALL ? '0 : pend_wall_vec) | ballwall_collide;
            pend_wall_dir <= (state == WALL ? '0 : pend_wall_dir) | collided_wall;
            pend_sweep    <= startOfFrame | (pend_sweep & (state != IDLE));
            pend_shot     <= shot_valid | (pend_shot & (state != SHOT));
            if (shot_valid) begin
                shot_x <= shot_x_speed;
                shot_y <= shot_y_speed;
            end
            // A new event may refill the slot in the same cycle the old one is consumed.
            if (|balls_collide && (!pend_ball || state == BALL)) begin
                pend_ball <= 1'b1;
                pend_id0  <= Balls_col_ID[3:0];
                pend_id1  <= Balls_col_ID[7:4];
            end else if (state == BALL) begin
                pend_ball <= 1'b0;
            end
            event_dropped <= |balls_collide && pend_ball && state != BALL;
            all_stopped   <= stop;
            busy          <= nstate != IDLE;
        end
    end

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_out
        assign x_speed[g*SPEED_W +: SPEED_W] = vx[g];
        assign y_speed[g*SPEED_W +: SPEED_W] = vy[g];
    end
endmodule
